instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 5-stage RV32I pipeline: owns the program counter, issues word reads to instruction memory over a req/ack handshake and presents fetched instructions with their PC to the IF/ID pipeline register. It absorbs variable memory latency and honours downstream stall and branch/jump redirect requests. When no valid instruction is available it drives a NOP bubble, because IF/ID captures every cycle.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- stall_i  in  1  downstream cannot accept the current output; hold it
- redirect_i  in  1  branch/jump taken; current path is wrong
- redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0
- imem_req_o  out  1  read request to instruction memory
- imem_addr_o  out  32  word-aligned read address
- imem_ack_i  in  1  read data valid this cycle
- imem_rdata_i  in  32  read data
- instruction_o  out  32  fetched instruction, NOP_INSTR when invalid
- pc_o  out  32  PC of instruction_o, 0 when invalid
- valid_o  out  1  instruction_o/pc_o hold a real instruction

## Operation
- All outputs registered. Internal: pc_q, state, output regs, one-entry skid (instr+pc), target_q.
- "Slot free" at an edge = !valid_o || !stall_i. When valid_o && !stall_i, the output is consumed at that edge.
- States:
  - BOOT: req=0. Next cycle -> REQ.
  - REQ: req=1, addr=pc_q. At an edge:
    - ack && redirect_i: drop rdata, pc_q<=redirect_pc_i, valid_o<=0, stay REQ.
    - ack && slot free: output<=rdata/pc_q, valid_o<=1, pc_q<=pc_q+4, stay REQ.
    - ack && slot busy: skid<=rdata/pc_q, pc_q<=pc_q+4, -> FULL.
    - !ack && redirect_i: target_q<=redirect_pc_i, valid_o<=0, -> DRAIN.
    - !ack, output consumed: valid_o<=0, outputs to bubble values.
  - FULL: req=0, output held. redirect_i: discard skid and output, pc_q<=redirect_pc_i, -> REQ. Else !stall_i: output<=skid, -> REQ.
  - DRAIN: req=1 at the unchanged old address until ack. Data dropped. Further redirect_i overwrites target_q. On ack: pc_q<=target_q (or redirect_pc_i if redirect_i also high), -> REQ.
- Priority: reset > redirect > stall.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Once asserted, imem_req_o and imem_addr_o stay stable until the acked edge. No request is ever withdrawn.
- valid_o=0 implies instruction_o=NOP_INSTR and pc_o=0.

## Timing
- Reset (async assert, sync release): state=BOOT, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instruction_o=NOP_INSTR, pc_o=0, valid_o=0.
- First request in the 2nd cycle after reset release.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, outputs valid the cycle after the acked edge.
- N wait cycles: N+1 cycles per instruction, with bubbles (valid_o=0) in between.
- Redirect with ack in the same cycle: first target-path request the next cycle. Redirect without ack: target request the cycle after the old request is acked.
- Reset mid-transaction: in-flight request abandoned. Memory must ignore a dangling ack after reset.
- Stall held indefinitely: at most one request completes into the skid, then req=0 until release.

## Test plan
- Reset, zero-wait memory returning addr-derived data -> imem_addr_o 0,4,8,12 on consecutive cycles; valid_o rises on the 3rd cycle after release with pc_o=0, then pc_o 4,8.
- Memory with 2 wait states -> each instruction valid 1 cycle, 2 bubble cycles between (instruction_o=0x00000013, valid_o=0); addr held stable while req=1.
- stall_i high for 5 cycles while pc_o=8 valid -> pc_o=8 held; the 12 fetch lands in skid; req=0; after release pc_o=12 next cycle, then 16 with no lost or duplicated PC.
- redirect_i to 0x100 while a request to 0x20 is waiting 3 cycles -> req stays at 0x20 until ack; its data never appears on the output; next addr 0x100; valid_o=0 throughout.
- redirect_i during FULL with target 0x204 -> skid dropped, next fetch 0x204, first valid pc_o=0x204.
- RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000. Async reset asserted mid-wait -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory read port: single outstanding word read over req/ack.
interface imem_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC ownership, imem req/ack, one-entry skid, redirect drain.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    imem_if.master       imem,
    output logic [31:0]  instruction_o,
    output logic [31:0]  pc_o,
    output logic         valid_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        FULL,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;
    logic            flush;

    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_inc;
    logic            slot_free;
    logic            consumed;

    assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign pc_inc       = pc_q + XLEN'(4);
    assign slot_free    = !valid_q || !stall_i;
    assign consumed     = valid_q && !stall_i;

    // Address is the PC register itself: it only moves on an acked edge or a redirect.
    assign imem.req      = req_q;
    assign imem.addr     = pc_q;
    assign instruction_o = instr_q;
    assign pc_o          = opc_q;
    assign valid_o       = valid_q;

    // Next-state, PC, skid and output-register selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        flush        = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem.ack) begin
                    if (redirect_i) begin
                        flush = 1'b1;
                        pc_d  = redirect_tgt;
                    end else if (slot_free) begin
                        instr_d = imem.rdata;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        skid_instr_d = imem.rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        state_d      = FULL;
                    end
                end else if (redirect_i) begin
                    flush    = 1'b1;
                    target_d = redirect_tgt;
                    state_d  = DRAIN;
                end else if (consumed) begin
                    flush = 1'b1;
                end
            end
            FULL: begin
                if (redirect_i) begin
                    flush   = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (!stall_i) begin
                    instr_d = skid_instr_q;
                    opc_d   = skid_pc_q;
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // Old request cannot be withdrawn; wait for its ack and drop the data.
                if (imem.ack) begin
                    pc_d    = redirect_i ? redirect_tgt : target_q;
                    state_d = REQ;
                end else if (redirect_i) begin
                    target_d = redirect_tgt;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (flush) begin
            instr_d = NOP_INSTR;
            opc_d   = '0;
            valid_d = 1'b0;
        end

        req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            instr_q      <= NOP_INSTR;
            opc_q        <= '0;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            valid_q      <= valid_d;
            req_q        <= req_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed timing scenarios plus randomized
// stall/redirect/latency traffic checked against an in-order PC stream model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] ALT_RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;

    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic [31:0] w_instruction;
    logic [31:0] w_pc;
    logic        w_valid;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_consumed = 0;

    // memory responder state
    int          mem_mode = 0;
    int          mem_wait = 0;
    int          mem_cnt = 0;
    bit          mem_pending = 1'b0;

    // reference model state
    logic [31:0] exp_pc = 32'h0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    imem_if mem ();
    imem_if w_mem ();

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    instruction_fetch_unit u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (mem),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    instruction_fetch_unit #(.RESET_PC(ALT_RESET_PC)) u_dut_wrap (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (w_stall),
        .redirect_i    (w_redirect),
        .redirect_pc_i (w_redirect_pc),
        .imem          (w_mem),
        .instruction_o (w_instruction),
        .pc_o          (w_pc),
        .valid_o       (w_valid)
    );

    // zero-wait memory for the wrap-around instance
    assign w_mem.ack   = w_mem.req;
    assign w_mem.rdata = data_of(w_mem.addr);

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One cycle at the negedge: answer memory, check protocol/bubble, advance model.
    task automatic tick();
        if (mem.req) begin
            if (!mem_pending) begin
                mem_pending = 1'b1;
                mem_cnt     = 0;
                mem_wait    = (mem_mode < 0) ? int'($urandom_range(3, 0)) : mem_mode;
            end
            if (mem_cnt >= mem_wait) begin
                mem.ack     = 1'b1;
                mem.rdata   = data_of(mem.addr);
                mem_pending = 1'b0;
            end else begin
                mem.ack   = 1'b0;
                mem.rdata = $urandom;
                mem_cnt++;
            end
        end else begin
            mem.ack   = 1'b0;
            mem.rdata = $urandom;
        end

        if (!valid_o) begin
            check("bubble_instr", instruction_o, NOP);
            check("bubble_pc", pc_o, 32'h0);
        end
        if (prev_req && !prev_ack) begin
            check("req_held", 32'(mem.req), 32'h1);
            check("addr_held", mem.addr, prev_addr);
        end

        if (redirect_i) begin
            exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (valid_o && !stall_i) begin
            check("seq_pc", pc_o, exp_pc);
            check("seq_instr", instruction_o, data_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end

        prev_req  = mem.req;
        prev_ack  = mem.ack;
        prev_addr = mem.addr;
        @(negedge clk);
    endtask

    // Returns at the negedge where reset is released (first cycle out of reset).
    task automatic apply_reset();
        reset_n     = 1'b0;
        stall_i     = 1'b0;
        redirect_i  = 1'b0;
        mem.ack     = 1'b0;
        mem.rdata   = 32'h0;
        mem_pending = 1'b0;
        prev_req    = 1'b0;
        prev_ack    = 1'b0;
        exp_pc      = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem.req), 32'h0);
        check("rst_addr", mem.addr, 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_instr", instruction_o, NOP);
        check("rst_pc", pc_o, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        bit found;
        int start;

        // zero-wait streaming, then a 5-cycle stall that fills the skid
        mem_mode = 0;
        apply_reset();
        check("p1_c1_req", 32'(mem.req), 32'h0);
        check("p1_c1_wreq", 32'(w_mem.req), 32'h0);
        tick();
        check("p1_c2_req", 32'(mem.req), 32'h1);
        check("p1_c2_addr", mem.addr, 32'h0);
        check("p1_c2_valid", 32'(valid_o), 32'h0);
        check("p1_c2_waddr", w_mem.addr, 32'hFFFF_FFF8);
        tick();
        check("p1_c3_addr", mem.addr, 32'h4);
        check("p1_c3_valid", 32'(valid_o), 32'h1);
        check("p1_c3_pc", pc_o, 32'h0);
        check("p1_c3_waddr", w_mem.addr, 32'hFFFF_FFFC);
        check("p1_c3_wpc", w_pc, 32'hFFFF_FFF8);
        tick();
        check("p1_c4_addr", mem.addr, 32'h8);
        check("p1_c4_pc", pc_o, 32'h4);
        check("p1_c4_waddr", w_mem.addr, 32'h0);
        check("p1_c4_wpc", w_pc, 32'hFFFF_FFFC);
        tick();
        check("p1_c5_addr", mem.addr, 32'hC);
        check("p1_c5_pc", pc_o, 32'h8);
        check("p1_c5_wpc", w_pc, 32'h0);
        check("p1_c5_wvalid", 32'(w_valid), 32'h1);
        stall_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("p1_stall_req", 32'(mem.req), 32'h0);
            check("p1_stall_pc", pc_o, 32'h8);
            check("p1_stall_valid", 32'(valid_o), 32'h1);
            tick();
        end
        stall_i = 1'b0;
        check("p1_rel_pc", pc_o, 32'h8);
        tick();
        check("p1_skid_pc", pc_o, 32'hC);
        check("p1_skid_valid", 32'(valid_o), 32'h1);
        tick();
        check("p1_after_pc", pc_o, 32'h10);
        tick();

        // two wait states per access, then async reset mid-wait
        mem_mode = 2;
        apply_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("p2_wait_req", 32'(mem.req), 32'h1);
            check("p2_wait_addr", mem.addr, 32'h0);
            check("p2_wait_valid", 32'(valid_o), 32'h0);
            tick();
        end
        check("p2_v0_valid", 32'(valid_o), 32'h1);
        check("p2_v0_pc", pc_o, 32'h0);
        check("p2_v0_addr", mem.addr, 32'h4);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("p2_bub_valid", 32'(valid_o), 32'h0);
            check("p2_bub_instr", instruction_o, NOP);
            tick();
        end
        check("p2_v1_valid", 32'(valid_o), 32'h1);
        check("p2_v1_pc", pc_o, 32'h4);
        tick();
        check("p2_pre_rst_req", 32'(mem.req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("p2_async_req", 32'(mem.req), 32'h0);
        check("p2_async_addr", mem.addr, 32'h0);
        check("p2_async_valid", 32'(valid_o), 32'h0);
        check("p2_async_instr", instruction_o, NOP);
        check("p2_async_pc", pc_o, 32'h0);
        check("p2_async_waddr", w_mem.addr, ALT_RESET_PC);

        // redirect while the request to 0x20 waits on a 3-wait-state memory
        mem_mode = 3;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem.req && mem.addr == 32'h20) found = 1'b1;
            else tick();
        end
        check("p3_found", 32'(found), 32'h1);
        if (found) begin
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h100;
            tick();
            redirect_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("p3_drain_req", 32'(mem.req), 32'h1);
                check("p3_drain_addr", mem.addr, 32'h20);
                check("p3_drain_valid", 32'(valid_o), 32'h0);
                tick();
            end
            check("p3_tgt_addr", mem.addr, 32'h100);
            for (int i = 0; i < 4; i++) begin
                check("p3_tgt_valid", 32'(valid_o), 32'h0);
                tick();
            end
            check("p3_first_valid", 32'(valid_o), 32'h1);
            check("p3_first_pc", pc_o, 32'h100);
            tick();
        end

        // redirect while the skid is full
        mem_mode = 0;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (valid_o && pc_o == 32'h8) found = 1'b1;
            else tick();
        end
        check("p4_found", 32'(found), 32'h1);
        if (found) begin
            stall_i = 1'b1;
            tick();
            check("p4_full_req", 32'(mem.req), 32'h0);
            check("p4_full_pc", pc_o, 32'h8);
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h204;
            tick();
            redirect_i = 1'b0;
            stall_i    = 1'b0;
            check("p4_tgt_req", 32'(mem.req), 32'h1);
            check("p4_tgt_addr", mem.addr, 32'h204);
            check("p4_tgt_valid", 32'(valid_o), 32'h0);
            tick();
            check("p4_first_valid", 32'(valid_o), 32'h1);
            check("p4_first_pc", pc_o, 32'h204);
            tick();
        end

        // randomized latency, stalls and (possibly misaligned) redirects
        mem_mode = -1;
        apply_reset();
        tick();
        tick();
        start = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            stall_i       = ($urandom_range(9, 0) < 3);
            redirect_i    = ($urandom_range(31, 0) == 0);
            redirect_pc_i = $urandom_range(32'h3FF, 0);
            tick();
        end
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        repeat (12) tick();
        check("rand_progress", 32'((n_consumed - start) >= 200), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
